// File: rtl/cfs_apb_master.sv
// APB3 requester: accepts one command at a time, runs SETUP/ACCESS on the bus
// and returns a single-cycle response, aborting hung transfers after a timeout.
module cfs_apb_master #(
  parameter int APB_ADDR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int TIMEOUT_CNT_WIDTH = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                      cmd_write,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [31:0]               pwdata,
  input  logic                      pready,
  input  logic [31:0]               prdata,
  input  logic                      pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] CntLast =
    TimeoutEn ? TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                       state_q;
  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q;
  logic [APB_ADDR_WIDTH-1:0]    paddr_q;
  logic                         pwrite_q;
  logic                         psel_q;
  logic                         penable_q;
  logic [31:0]                  pwdata_q;
  logic                         rsp_valid_q;
  logic [31:0]                  rsp_rdata_q;
  logic                         rsp_slverr_q;
  logic                         rsp_timeout_q;

  assign cmd_ready   = (state_q == IDLE) && !preset;
  assign busy        = (state_q != IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_write ? cmd_wdata : 32'h0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          // pready takes priority over a timeout expiring in the same cycle
          if (pready) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= pslverr;
            rsp_rdata_q   <= pwrite_q ? 32'h0 : prdata;
            rsp_timeout_q <= 1'b0;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfs_apb_master.sv
// Randomized scoreboard bench for cfs_apb_master: a completer stub with
// programmable wait states, a reference register model and a response monitor.
module tb_cfs_apb_master;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    int          accept;
    int          due;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_slverr, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  logic        d0_preset = 1'b1;
  logic        d0_cmd_valid = 1'b0;
  logic        d0_cmd_ready;
  logic        d0_rsp_valid, d0_rsp_slverr, d0_rsp_timeout, d0_busy;
  logic [31:0] d0_rsp_rdata;
  logic [15:0] d0_paddr;
  logic        d0_pwrite, d0_psel, d0_penable;
  logic [31:0] d0_pwdata;
  logic        d0_pready = 1'b0;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   stub_wait_q[$];
  int   lastAccept = 0;
  logic [31:0] model_mem [logic [15:0]];
  logic [31:0] stub_mem [logic [15:0]];

  cfs_apb_master #(.APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(16), .TIMEOUT_CNT_WIDTH(16)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .busy(busy), .paddr(paddr), .pwrite(pwrite),
    .psel(psel), .penable(penable), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr));

  cfs_apb_master #(.APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(0), .TIMEOUT_CNT_WIDTH(16)) dut0 (
    .pclk(pclk), .preset(d0_preset), .cmd_valid(d0_cmd_valid), .cmd_ready(d0_cmd_ready),
    .cmd_addr(16'h0040), .cmd_write(1'b1), .cmd_wdata(32'hCAFE_0001),
    .rsp_valid(d0_rsp_valid), .rsp_rdata(d0_rsp_rdata), .rsp_slverr(d0_rsp_slverr),
    .rsp_timeout(d0_rsp_timeout), .busy(d0_busy), .paddr(d0_paddr), .pwrite(d0_pwrite),
    .psel(d0_psel), .penable(d0_penable), .pwdata(d0_pwdata), .pready(d0_pready),
    .prdata(32'hFFFF_FFFF), .pslverr(1'b1));

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Completer register map behaviour: STATUS is read-only, CTRL SIZE=0 is illegal, 0xFxxx unmapped.
  function automatic logic isErr(input logic [15:0] a, input logic wr, input logic [31:0] wd);
    return (wr && a == 16'h000C) || (wr && a == 16'h0000 && wd[2:0] == 3'd0) || (a[15:12] == 4'hF);
  endfunction

  function automatic logic [31:0] modelRead(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] stubRead(input logic [15:0] a);
    return stub_mem.exists(a) ? stub_mem[a] : 32'h0;
  endfunction

  // Issue one command; w is the number of completer wait states (>=16 means never ready).
  task automatic applyStimulus(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                               input int w, input bit hold);
    exp_t r;
    int n = 0;
    cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    r.addr = a; r.wr = wr; r.wdata = wd; r.accept = cyc + 1;
    if (w >= 16) begin
      r.rdata = 32'h0; r.slverr = 1'b1; r.tmo = 1'b1; r.due = r.accept + 17;
    end else begin
      r.slverr = isErr(a, wr, wd);
      r.rdata  = wr ? 32'h0 : modelRead(a);
      r.tmo    = 1'b0;
      r.due    = r.accept + 2 + w;
      if (wr && !r.slverr) model_mem[a] = wd;
    end
    exp_q.push_back(r);
    stub_wait_q.push_back(w);
    lastAccept = r.accept;
    @(negedge pclk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Completer stub: drives junk outside the completing cycle so ignored inputs are exercised.
  int curWait = 0;
  int accCnt = 0;
  always @(negedge pclk) begin
    if (preset) begin
      pready = 1'b0;
    end else if (psel && !penable) begin
      curWait = (stub_wait_q.size() > 0) ? stub_wait_q.pop_front() : 0;
      accCnt  = 0;
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end else if (psel && penable) begin
      if (accCnt == curWait) begin
        pready  = 1'b1;
        pslverr = isErr(paddr, pwrite, pwdata);
        prdata  = stubRead(paddr);
        if (pwrite && !pslverr) stub_mem[paddr] = pwdata;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
        accCnt++;
      end
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
  end

  exp_t mr;
  bit   inWin;
  always @(negedge pclk) begin
    if (!preset) begin
      inWin = (exp_q.size() > 0) && (cyc >= exp_q[0].accept) && (cyc < exp_q[0].due);
      if (inWin) begin
        mr = exp_q[0];
        checkOutput("apb_phase", {psel, penable, pwrite, paddr, pwdata},
                    {1'b1, (cyc > mr.accept), mr.wr, mr.addr, (mr.wr ? mr.wdata : 32'h0)});
      end else begin
        checkOutput("apb_idle", {psel, penable}, 2'b00);
      end
      checkOutput("busy_ready", {busy, cmd_ready}, {inWin, !inWin});
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mr = exp_q.pop_front();
          checkOutput("rsp_fields", {rsp_timeout, rsp_slverr, rsp_rdata},
                      {mr.tmo, mr.slverr, mr.rdata});
          checkOutput("rsp_latency", 64'(cyc - mr.accept), 64'(mr.due - mr.accept));
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        mr = exp_q.pop_front();
        checkOutput("rsp_missing", 64'(rsp_valid), 64'd1);
      end
    end
  end

  logic [15:0] ra;
  int          acc0;
  bit          seen;
  initial begin
    model_mem[16'h00F0] = 32'h0000_001F;
    stub_mem[16'h00F0]  = 32'h0000_001F;
    repeat (3) @(negedge pclk);
    checkOutput("reset_state", {cmd_ready, busy, psel, penable, pwrite, rsp_valid,
                rsp_slverr, rsp_timeout, rsp_rdata, paddr}, 64'h0);
    preset = 1'b0; d0_preset = 1'b0;
    @(negedge pclk);
    checkOutput("ready_after_reset", {cmd_ready, busy}, 2'b10);

    applyStimulus(16'h0000, 1'b1, 32'h0000_0001, 0, 1'b0);
    drain();
    applyStimulus(16'h00F0, 1'b0, 32'h1234_5678, 0, 1'b0);
    drain();
    applyStimulus(16'h000C, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    drain();
    applyStimulus(16'h0000, 1'b1, 32'h0000_0000, 1, 1'b0);
    drain();
    applyStimulus(16'h0008, 1'b1, 32'hA5A5_0003, 15, 1'b0);
    drain();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0077, 100, 1'b0);
    drain();

    // Back-to-back with cmd_valid held high against a zero-wait completer.
    for (int i = 0; i < 4; i++) begin
      acc0 = lastAccept;
      applyStimulus(16'h0010 + 16'(i * 4), 1'(i % 2), 32'h100 + 32'(i), 0, 1'b1);
      if (i > 0) checkOutput("b2b_spacing", 64'(lastAccept - acc0), 64'd3);
    end
    cmd_valid = 1'b0;
    drain();

    // Reset while a hung transfer sits in ACCESS.
    applyStimulus(16'h00F0, 1'b0, 32'h0, 0, 1'b0);
    drain();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0055, 1000, 1'b0);
    while (cyc < lastAccept + 4) @(negedge pclk);
    preset = 1'b1;
    exp_q.delete();
    stub_wait_q.delete();
    @(negedge pclk);
    checkOutput("reset_abort", {psel, penable, rsp_valid, rsp_slverr, rsp_timeout, busy, rsp_rdata}, 64'h0);
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("ready_after_abort", {cmd_ready, busy, rsp_valid}, 3'b100);
    applyStimulus(16'h0004, 1'b0, 32'h0, 0, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'h0000;
        1: ra = 16'h0004;
        2: ra = 16'h000C;
        3: ra = 16'h00F0;
        4: ra = {4'hF, 12'($urandom)};
        default: ra = 16'($urandom) & 16'h0FFC;
      endcase
      applyStimulus(ra, 1'($urandom), $urandom,
                    ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)),
                    1'($urandom));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end
    drain();

    // Timeout disabled: a never-ready completer leaves the transfer pending forever.
    checkOutput("d0_ready", 64'(d0_cmd_ready), 64'd1);
    d0_cmd_valid = 1'b1;
    @(negedge pclk);
    d0_cmd_valid = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      @(negedge pclk);
      if (d0_rsp_valid) seen = 1'b1;
    end
    checkOutput("d0_no_rsp", {seen, d0_rsp_slverr, d0_rsp_timeout, d0_rsp_rdata}, 64'h0);
    checkOutput("d0_hung", {d0_busy, d0_psel, d0_penable, d0_cmd_ready, d0_pwrite, d0_paddr, d0_pwdata},
                {4'b1110, 1'b1, 16'h0040, 32'hCAFE_0001});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cfs_apb_master.md
Name: cfs_apb_master

Overview:
- APB requester that turns simple command/response transactions into APB3 transfers.
- Used on the test/control side to drive the Aligner register block (CTRL, STATUS, IRQEN, IRQ) or any other APB completer in the design.
- Handles one outstanding transfer at a time, tolerates completer wait states, and aborts a hung transfer after a programmable timeout.

Parameters:
APB_ADDR_WIDTH, 16, width of cmd_addr/paddr
TIMEOUT_CYCLES, 64, max ACCESS cycles waiting for pready; 0 disables timeout
TIMEOUT_CNT_WIDTH, 16, width of internal wait counter; must hold TIMEOUT_CYCLES

Ports:
pclk  input  1  clock
preset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_addr  input  APB_ADDR_WIDTH  transfer address
cmd_write  input  1  1=write, 0=read
cmd_wdata  input  32  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read data (0 for writes/timeouts)
rsp_slverr  output  1  error response (pslverr or timeout)
rsp_timeout  output  1  transfer aborted by timeout
busy  output  1  state != IDLE
paddr  output  APB_ADDR_WIDTH  APB address
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB enable
pwdata  output  32  APB write data
pready  input  1  completer ready
prdata  input  32  completer read data
pslverr  input  1  completer error

Behaviour:
- Reset: interface is synchronous, active-high (preset sampled on pclk rising edge). State=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0; counter=0.
- Reset mid-transfer: psel/penable low the cycle after preset is sampled high. No rsp_valid is issued for the aborted transfer.
- All APB and rsp outputs are registered. cmd_ready = (state==IDLE) & !preset, combinational.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: on cmd_valid & cmd_ready, latch the command.
  - Next cycle: state=SETUP, psel=1, penable=0, paddr=cmd_addr (unmodified, no alignment), pwrite=cmd_write, pwdata=cmd_write ? cmd_wdata : 0.
- SETUP: unconditionally go to ACCESS; penable=1, counter cleared.
- ACCESS: paddr/pwrite/pwdata/psel held stable.
  - pready=1 sampled: next cycle state=IDLE, psel=penable=0, rsp_valid=1, rsp_slverr=pslverr, rsp_rdata = pwrite ? 0 : prdata, rsp_timeout=0.
  - pready=0 and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: next cycle IDLE, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - Otherwise counter++. If pready and timeout occur in the same cycle, pready wins.
- rsp_valid is high exactly one cycle. rsp_rdata/rsp_slverr/rsp_timeout hold their value until the next response and are cleared only by reset.
- Latency: accept in cycle N; SETUP in N+1; ACCESS from N+2. Zero-wait-state response in N+3, where cmd_ready is already high, so back-to-back commands start every 3 cycles.
- Every ACCESS wait cycle adds one cycle of latency.
- prdata and pslverr are sampled only in ACCESS with pready=1; ignored at all other times.
- cmd_* inputs are ignored while busy; no command buffering.

Test Plan:
- Write CTRL addr 0x0000, wdata 0x0000_0001 to the Aligner register block -> psel/penable protocol correct, pready in 1st ACCESS cycle, rsp_valid at N+3, rsp_slverr=0, rsp_rdata=0.
- Read IRQEN addr 0x00F0 after reset -> rsp_rdata=0x0000_001F, rsp_slverr=0; then write STATUS addr 0x000C -> rsp_slverr=1, rsp_timeout=0.
- Write CTRL wdata 0x0000_0000 (SIZE=0, illegal) -> completer inserts 1 wait state, ACCESS lasts 2 cycles with paddr/pwdata stable, rsp_slverr=1, rsp at N+4.
- TIMEOUT_CYCLES=16, stub holds pready=0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. With TIMEOUT_CYCLES=0 and pready=0 for 200 cycles -> no response, busy=1.
- cmd_valid held high with 4 queued commands against a zero-wait stub -> accepts every 3 cycles, 4 rsp_valid pulses in order, cmd_ready low while busy.
- Assert preset during ACCESS with pready=0 -> psel=penable=0 next cycle, no rsp_valid, cmd_ready=1 after preset drops, next command completes normally.
